// File: rtl/sd_resp_rx_ctrl.sv
// SD CMD-line response receiver: finds the start bit, gates 48 shifts into the
// downstream shift register, runs CRC7 over the first 40 bits and decodes the word.
module sd_resp_rx_ctrl #(
    parameter int unsigned TIMEOUT_BITS = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        arm,
    input  logic        ignore_crc,
    input  logic        sample_en,
    input  logic        cmd_in,
    input  logic [47:0] parallel_in,
    output logic        shift_enable,
    output logic        busy,
    output logic        resp_valid,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        resp_crc_err,
    output logic        resp_frame_err,
    output logic        resp_timeout
);

    localparam int unsigned NUM_BITS = 48;
    localparam int unsigned CRC_BITS = 40;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       crc_q, crc_d;
    logic             ign_q, ign_d;
    logic             load_c, timeout_c, shift_c;

    logic        valid_q, valid_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] arg_q, arg_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_err_q, frame_err_d;
    logic        timeout_q, timeout_d;

    // The start bit is implied by reaching SHIFT; it is not re-checked.
    logic unused_start_bit;
    assign unused_start_bit = parallel_in[47];

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Next-state, counter and CRC logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        ign_d     = ign_q;
        load_c    = 1'b0;
        timeout_c = 1'b0;
        shift_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    crc_d   = '0;
                    ign_d   = ignore_crc;
                end
            end
            S_WAIT: begin
                if (sample_en) begin
                    if (!cmd_in) begin
                        shift_c = 1'b1;
                        cnt_d   = CNT_W'(1);
                        crc_d   = crc7_step(crc_q, 1'b0);
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(TIMEOUT_BITS)) begin
                            state_d   = S_CHECK;
                            load_c    = 1'b1;
                            timeout_c = 1'b1;
                        end
                    end
                end
            end
            S_SHIFT: begin
                shift_c = sample_en;
                if (sample_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q < CNT_W'(CRC_BITS)) begin
                        crc_d = crc7_step(crc_q, cmd_in);
                    end
                    if (cnt_d == CNT_W'(NUM_BITS)) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                state_d = S_CHECK;
                load_c  = 1'b1;
            end
            S_CHECK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result registers load on entry to CHECK so the valid pulse spans the CHECK cycle.
    always_comb begin
        valid_d     = load_c;
        index_d     = index_q;
        arg_d       = arg_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;
        if (load_c) begin
            if (timeout_c) begin
                timeout_d   = 1'b1;
                crc_err_d   = 1'b0;
                frame_err_d = 1'b0;
            end else begin
                timeout_d   = 1'b0;
                index_d     = parallel_in[45:40];
                arg_d       = parallel_in[39:8];
                crc_err_d   = !ign_q && (crc_q != parallel_in[7:1]);
                frame_err_d = parallel_in[46] | ~parallel_in[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            crc_q       <= '0;
            ign_q       <= 1'b0;
            valid_q     <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            ign_q       <= ign_d;
            valid_q     <= valid_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign shift_enable   = shift_c;
    assign busy           = (state_q != S_IDLE);
    assign resp_valid     = valid_q;
    assign resp_index     = index_q;
    assign resp_arg       = arg_q;
    assign resp_crc_err   = crc_err_q;
    assign resp_frame_err = frame_err_q;
    assign resp_timeout   = timeout_q;

endmodule
